// File: rtl/rle_block_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : rle_block_decoder_if
//  Description : Symbol-in / coefficient-out bundle for rle_block_decoder.
//                master = symbol producer and coefficient consumer.
//                slave  = the decoder itself.
//  Signals     : sym_valid/sym_ready/sym_run/sym_level/sym_eob  (symbol in)
//                coef_valid/coef_ready/coef_data/coef_idx/coef_last (out)
//                err_overflow (run overflow pulse)
//  Revision    : 1.0  initial release
// ============================================================================
interface rle_block_decoder_if #(
    parameter int COEF_W = 9
);
    logic                     sym_valid;
    logic                     sym_ready;
    logic [5:0]               sym_run;
    logic signed [COEF_W-1:0] sym_level;
    logic                     sym_eob;
    logic                     coef_valid;
    logic                     coef_ready;
    logic signed [COEF_W-1:0] coef_data;
    logic [5:0]               coef_idx;
    logic                     coef_last;
    logic                     err_overflow;

    modport master (
        output sym_valid, sym_run, sym_level, sym_eob, coef_ready,
        input  sym_ready, coef_valid, coef_data, coef_idx, coef_last, err_overflow
    );

    modport slave (
        input  sym_valid, sym_run, sym_level, sym_eob, coef_ready,
        output sym_ready, coef_valid, coef_data, coef_idx, coef_last, err_overflow
    );
endinterface
`default_nettype wire

// File: rtl/rle_block_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rle_block_decoder
//  Description : Converts (run, level) symbols into 8x8 blocks of signed
//                coefficients, de-zigzagged to raster order, and streams each
//                finished block out one coefficient per cycle. Two ping-pong
//                banks allow one block to fill while the other drains.
//  Ports       : clk, rst (sync, active high)
//                bus.slave : symbol input handshake, coefficient output
//                            handshake, err_overflow pulse
//  Option      : RLE_DEC_DC_DPCM_EN - DC value at zigzag 0 is coded as a
//                difference against a saturating running predictor.
//  Revision    : 1.0  initial release
// ============================================================================
module rle_block_decoder #(
    parameter int COEF_W = 9
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rle_block_decoder_if.slave   bus
);

    // Zigzag index -> raster index (standard JPEG order)
    localparam logic [5:0] c_ZZ2R [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] r_mem [2][64];
    logic [63:0]              r_mask [2];
    logic [1:0]               r_full;
    logic                     r_fill_bank;
    logic                     r_rd_bank;
    logic [5:0]               r_zz;
    logic [5:0]               r_r;
    logic                     r_err;
    logic [0:0]               r_fill_state;
    logic [0:0]               w_fill_next;
    logic [0:0]               r_drn_state;
    logic [0:0]               w_drn_next;
`ifdef RLE_DEC_DC_DPCM_EN
    logic signed [COEF_W-1:0] r_dc_pred;
`endif

    // ------------------------------------------------------------------
    // Fill-side datapath
    // ------------------------------------------------------------------
    logic                     w_sym_fire;
    logic [6:0]               w_sum;
    logic                     w_ovf;
    logic                     w_wr;
    logic [5:0]               w_wr_pos;
    logic signed [COEF_W-1:0] w_wr_val;
    logic                     w_complete;
    logic                     w_drain_fire;
    logic                     w_drain_done;

    assign w_sym_fire = bus.sym_valid && (r_fill_state == c_ST_FILL);
    // 7-bit sum so that zz+run > 63 shows up in bit 6
    assign w_sum      = {1'b0, r_zz} + {1'b0, bus.sym_run};
    assign w_ovf      = w_sym_fire && !bus.sym_eob && w_sum[6];
    assign w_wr       = w_sym_fire && !bus.sym_eob && !w_sum[6];
    assign w_wr_pos   = c_ZZ2R[w_sum[5:0]];
    assign w_complete = w_sym_fire && (bus.sym_eob || w_sum[6] || (w_sum == 7'd63));

`ifdef RLE_DEC_DC_DPCM_EN
    logic                     w_is_dc;
    logic signed [COEF_W:0]   w_dc_sum;
    logic                     w_dc_fill;

    assign w_is_dc  = (w_sum == 7'd0);
    assign w_dc_sum = {r_dc_pred[COEF_W-1], r_dc_pred} + {bus.sym_level[COEF_W-1], bus.sym_level};
    // A block that never wrote zigzag 0 gets the predictor stored there at
    // completion, so the drain side needs no special case for raster 0.
    // A zigzag-0 write can never be the completing symbol, so the two never
    // collide.
    assign w_dc_fill = w_complete && !r_mask[r_fill_bank][0];

    always_comb begin
        w_wr_val = bus.sym_level;
        if (w_is_dc) begin
            // Top two bits differ only when the sum left the COEF_W range
            if (w_dc_sum[COEF_W] != w_dc_sum[COEF_W-1]) begin
                w_wr_val = w_dc_sum[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}}
                                            : {1'b0, {(COEF_W-1){1'b1}}};
            end else begin
                w_wr_val = w_dc_sum[COEF_W-1:0];
            end
        end
    end
`else
    assign w_wr_val = bus.sym_level;
`endif

    // ------------------------------------------------------------------
    // Drain-side handshake
    // ------------------------------------------------------------------
    assign w_drain_fire = (r_drn_state == c_ST_SEND) && bus.coef_ready;
    assign w_drain_done = w_drain_fire && (r_r == 6'd63);

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_fill_state <= c_ST_FILL;
        else     r_fill_state <= w_fill_next;
    end

    always_comb begin
        w_fill_next = r_fill_state;
        case (r_fill_state)
            c_ST_FILL: begin
                // The other bank can only be full if it is the one draining;
                // if it is being freed on this very edge, keep filling.
                if (w_complete && r_full[~r_fill_bank] &&
                    !(w_drain_done && (r_rd_bank != r_fill_bank))) begin
                    w_fill_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_drain_done && (r_rd_bank == r_fill_bank)) begin
                    w_fill_next = c_ST_FILL;
                end
            end
            default: w_fill_next = c_ST_FILL;
        endcase
    end

    always_comb begin
        bus.sym_ready    = (r_fill_state == c_ST_FILL);
        bus.err_overflow = r_err;
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_drn_state <= c_ST_IDLE;
        else     r_drn_state <= w_drn_next;
    end

    always_comb begin
        w_drn_next = r_drn_state;
        case (r_drn_state)
            c_ST_IDLE: begin
                if (r_full[r_rd_bank]) w_drn_next = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_drain_done) begin
                    w_drn_next = (r_full[~r_rd_bank] ||
                                  (w_complete && (r_fill_bank != r_rd_bank)))
                                 ? c_ST_SEND : c_ST_IDLE;
                end
            end
            default: w_drn_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.coef_valid = (r_drn_state == c_ST_SEND);
        bus.coef_idx   = r_r;
        bus.coef_last  = (r_drn_state == c_ST_SEND) && (r_r == 6'd63);
        bus.coef_data  = '0;
        if ((r_drn_state == c_ST_SEND) && r_mask[r_rd_bank][r_r]) begin
            bus.coef_data = r_mem[r_rd_bank][r_r];
        end
    end

    // ------------------------------------------------------------------
    // Coefficient storage (validity tracked by the mask, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_fill_bank][w_wr_pos] <= w_wr_val;
`ifdef RLE_DEC_DC_DPCM_EN
        if (w_dc_fill) r_mem[r_fill_bank][0] <= r_dc_pred;
`endif
    end

    // ------------------------------------------------------------------
    // Bank bookkeeping, pointers and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_bank <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_zz        <= '0;
            r_r         <= '0;
            r_full      <= '0;
            r_mask[0]   <= '0;
            r_mask[1]   <= '0;
            r_err       <= 1'b0;
`ifdef RLE_DEC_DC_DPCM_EN
            r_dc_pred   <= '0;
`endif
        end else begin
            r_err <= w_ovf;

            if (w_wr) r_mask[r_fill_bank][w_wr_pos] <= 1'b1;
`ifdef RLE_DEC_DC_DPCM_EN
            if (w_wr && w_is_dc) r_dc_pred <= w_wr_val;
            if (w_dc_fill) r_mask[r_fill_bank][0] <= 1'b1;
`endif

            if (w_complete) begin
                r_full[r_fill_bank] <= 1'b1;
                r_fill_bank         <= ~r_fill_bank;
                r_zz                <= '0;
            end else if (w_wr) begin
                r_zz <= w_sum[5:0] + 6'd1;
            end

            // The mask is cleared as the bank is freed, so a bank handed
            // to the fill side is always already clean. Fill and drain
            // never touch the same bank in one cycle.
            if (w_drain_done) begin
                r_full[r_rd_bank] <= 1'b0;
                r_mask[r_rd_bank] <= '0;
                r_rd_bank         <= ~r_rd_bank;
                r_r               <= '0;
            end else if (w_drain_fire) begin
                r_r <= r_r + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_block_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rle_block_decoder
//  Description : Self-checking bench for rle_block_decoder. A reference model
//                turns every accepted symbol into expected raster blocks that
//                are queued and compared against the coefficient stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rle_block_decoder;

    localparam int COEF_W = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rle_block_decoder_if #(.COEF_W(COEF_W)) bus ();

    rle_block_decoder #(.COEF_W(COEF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int data;
        bit last;
    } exp_t;

    typedef struct {
        int run;
        int level;
        bit eob;
        bit exp_err;
        bit chk_lat;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   zz2r[64];
    int   n_total = 0;
    int   n_bad   = 0;

    // reference model state
    int m_zz;
    int m_blk[64];
    bit m_wr0;
    int m_dc;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Zigzag order derived by walking anti-diagonals
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz2r[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz2r[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    task automatic model_reset();
        m_zz = 0; m_wr0 = 0; m_dc = 0;
        for (int i = 0; i < 64; i++) m_blk[i] = 0;
    endtask

    task automatic model_sym(input int run, input int level, input bit eob);
        bit done = 0;
        int p, v;
        if (eob) done = 1;
        else if (m_zz + run > 63) done = 1;
        else begin
            p = m_zz + run;
            v = level;
`ifdef RLE_DEC_DC_DPCM_EN
            if (p == 0) begin
                v = m_dc + level;
                if (v > (1 << (COEF_W - 1)) - 1) v = (1 << (COEF_W - 1)) - 1;
                if (v < -(1 << (COEF_W - 1)))    v = -(1 << (COEF_W - 1));
                m_dc  = v;
                m_wr0 = 1;
            end
`endif
            m_blk[zz2r[p]] = v;
            m_zz = p + 1;
            if (m_zz == 64) done = 1;
        end
        if (done) begin
`ifdef RLE_DEC_DC_DPCM_EN
            if (!m_wr0) m_blk[0] = m_dc;
`endif
            for (int i = 0; i < 64; i++) q.push_back('{i, m_blk[i], i == 63});
            for (int i = 0; i < 64; i++) m_blk[i] = 0;
            m_zz = 0; m_wr0 = 0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int run, input int level, input bit eob);
        bit ok = 0;
        bus.sym_valid = 1'b1;
        bus.sym_run   = run[5:0];
        bus.sym_level = level[COEF_W-1:0];
        bus.sym_eob   = eob;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (bus.sym_ready === 1'b1) ok = 1;
            @(posedge clk);
            #1;
        end
        bus.sym_valid = 1'b0;
        bus.sym_eob   = 1'b0;
        if (ok) model_sym(run, level, eob);
        else    chk("sym_accept_timeout", 0, 1);
    endtask

    task automatic wait_drained();
        for (int c = 0; c < 600 && q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
    endtask

    // Scoreboard: a handshake visible at the falling edge completes on the
    // next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.coef_valid === 1'b1 && bus.coef_ready === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("unexpected_coef_idx", int'(bus.coef_idx), -1);
            end else begin
                e = q.pop_front();
                chk("coef_idx",  int'(bus.coef_idx), e.idx);
                chk("coef_data", int'($signed(bus.coef_data)), e.data);
                chk("coef_last", int'(bus.coef_last), int'(e.last));
            end
        end
    end

    initial begin
        bit found;

        build_zz();
        vecs[0] = '{0,  5, 0, 0, 0};
        vecs[1] = '{0, -3, 0, 0, 0};
        vecs[2] = '{1,  2, 0, 0, 0};
        vecs[3] = '{0,  0, 1, 0, 1};
        vecs[4] = '{60, 1, 0, 0, 0};
        vecs[5] = '{5,  7, 0, 1, 0};

        bus.sym_valid  = 1'b0;
        bus.sym_run    = '0;
        bus.sym_level  = '0;
        bus.sym_eob    = 1'b0;
        bus.coef_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_ready",  int'(bus.sym_ready), 1);
        chk("rst_coef_valid", int'(bus.coef_valid), 0);
        chk("rst_coef_data",  int'($signed(bus.coef_data)), 0);
        chk("rst_coef_idx",   int'(bus.coef_idx), 0);
        chk("rst_coef_last",  int'(bus.coef_last), 0);
        chk("rst_err",        int'(bus.err_overflow), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic block, latency, and run overflow
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].run, vecs[i].level, vecs[i].eob);
            chk("err_overflow", int'(bus.err_overflow), int'(vecs[i].exp_err));
            if (vecs[i].chk_lat) begin
                chk("lat_valid_n1", int'(bus.coef_valid), 0);
                @(posedge clk);
                #1;
                chk("lat_valid_n2", int'(bus.coef_valid), 1);
            end
        end
        @(posedge clk);
        #1;
        chk("err_single_pulse", int'(bus.err_overflow), 0);
        wait_drained();

        // Full block of 64 symbols without EOB, then a new block
        for (int k = 0; k < 64; k++) send(0, k, 0);
        send(0, 9, 0);
        send(0, 0, 1);
        wait_drained();

        // Back-pressure: both banks fill, third EOB waits for a free bank
        bus.coef_ready = 1'b0;
        send(0, 0, 1);
        send(0, 0, 1);
        chk("bp_sym_ready_low", int'(bus.sym_ready), 0);
        fork
            send(0, 0, 1);
            begin
                repeat (5) begin @(posedge clk); #1; end
                chk("bp_hold_valid", int'(bus.coef_valid), 1);
                chk("bp_hold_idx",   int'(bus.coef_idx), 0);
                chk("bp_hold_data",  int'($signed(bus.coef_data)), 0);
                chk("bp_still_full", int'(bus.sym_ready), 0);
                bus.coef_ready = 1'b1;
            end
        join
        wait_drained();

`ifdef RLE_DEC_DC_DPCM_EN
        // DC prediction with saturation and a DC-less block
        send(0, 250, 0);
        send(0, 0, 1);
        send(0, 10, 0);
        send(0, 0, 1);
        send(0, 0, 1);
        wait_drained();
`endif

        // Reset in the middle of a drain
        send(0, 7, 0);
        send(2, -4, 0);
        send(0, 0, 1);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.coef_valid === 1'b1 && bus.coef_idx == 6'd30) found = 1;
        end
        chk("reach_idx30", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid",     int'(bus.coef_valid), 0);
        chk("mid_rst_sym_ready", int'(bus.sym_ready), 1);
        chk("mid_rst_idx",       int'(bus.coef_idx), 0);
        chk("mid_rst_last",      int'(bus.coef_last), 0);
        rst = 1'b0;
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        send(0, 11, 0);
        send(3, -2, 0);
        send(0, 0, 1);
        wait_drained();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
